// File: rtl/ascon_pad_packer.sv
// Packs byte-granular message beats into ASCON rate blocks and applies 10* padding.
// Optional block-transfer counter on blk_cnt_o when ASCON_PACK_STATS_EN is defined.
module ascon_pad_packer #(
   parameter int IN_BYTES   = 4,
   parameter int RATE_BYTES = 16
) (
   input  logic                                clock_i,
   input  logic                                reset_i,
   input  logic [8*IN_BYTES-1:0]               in_data_i,
   input  logic [$clog2(IN_BYTES+1)-1:0]       in_nbytes_i,
   input  logic                                in_last_i,
   input  logic                                in_type_i,
   input  logic                                in_valid_i,
   output logic                                in_ready_o,
   output logic [8*RATE_BYTES-1:0]             blk_data_o,
   output logic [$clog2(RATE_BYTES+1)-1:0]     blk_nbytes_o,
   output logic                                blk_type_o,
   output logic                                blk_last_o,
   output logic                                blk_valid_o,
   input  logic                                blk_ready_i,
`ifdef ASCON_PACK_STATS_EN
   output logic [15:0]                         blk_cnt_o,
`endif
   output logic                                err_o
);

   // state  | meaning
   // FILL   | accepting beats into the block buffer
   // EMIT   | presenting a data block (full or padded)
   // PADBLK | presenting the extra pad-only block after an exactly full last block
   typedef enum logic [1:0] {FILL, EMIT, PADBLK} state_t;

   localparam int PW = $clog2(RATE_BYTES+1);

   state_t                  state_q;
   logic [PW-1:0]           ptr_q;
   logic                    pad_pend_q;
   logic                    in_msg_q;

   logic [8*RATE_BYTES-1:0] fill_data;
   logic                    nb_bad;
   logic                    beat_err;
   int                      p_i;
   int                      n_i;
   int                      np_i;

   always_comb begin
      p_i    = int'(ptr_q);
      n_i    = int'(in_nbytes_i);
      nb_bad = (n_i == 0) || (n_i > IN_BYTES);
      if (nb_bad) n_i = IN_BYTES;
      np_i = p_i + n_i;
      if (np_i > RATE_BYTES) np_i = RATE_BYTES;

      // Bytes beyond the rate are dropped if a malformed stream misaligns the pointer.
      fill_data = blk_data_o;
      for (int j = 0; j < RATE_BYTES; j++) begin
         for (int k = 0; k < IN_BYTES; k++) begin
            if (k < n_i && j == p_i + k) fill_data[j*8 +: 8] = in_data_i[k*8 +: 8];
         end
         if (in_last_i && j == np_i) fill_data[j*8 +: 8] = 8'h01;
      end

      beat_err = nb_bad
               || (int'(in_nbytes_i) < IN_BYTES && !in_last_i)
               || (in_msg_q && in_type_i != blk_type_o);
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= FILL;
         ptr_q        <= '0;
         pad_pend_q   <= 1'b0;
         in_msg_q     <= 1'b0;
         err_o        <= 1'b0;
         in_ready_o   <= 1'b0;
         blk_valid_o  <= 1'b0;
         blk_data_o   <= '0;
         blk_nbytes_o <= '0;
         blk_type_o   <= 1'b0;
         blk_last_o   <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               in_ready_o <= 1'b1;
               if (in_valid_i && in_ready_o) begin
                  if (beat_err) err_o <= 1'b1;
                  if (!in_msg_q) blk_type_o <= in_type_i;
                  in_msg_q   <= !in_last_i;
                  blk_data_o <= fill_data;
                  ptr_q      <= PW'(np_i);
                  if (np_i == RATE_BYTES || in_last_i) begin
                     state_q      <= EMIT;
                     in_ready_o   <= 1'b0;
                     blk_valid_o  <= 1'b1;
                     blk_nbytes_o <= PW'(np_i);
                     blk_last_o   <= in_last_i && (np_i < RATE_BYTES);
                     pad_pend_q   <= in_last_i && (np_i == RATE_BYTES);
                  end
               end
            end
            EMIT, PADBLK: begin
               if (blk_ready_i) begin
                  ptr_q        <= '0;
                  blk_nbytes_o <= '0;
                  if (pad_pend_q) begin
                     state_q    <= PADBLK;
                     pad_pend_q <= 1'b0;
                     blk_data_o <= {{(8*RATE_BYTES-8){1'b0}}, 8'h01};
                     blk_last_o <= 1'b1;
                  end else begin
                     state_q     <= FILL;
                     blk_valid_o <= 1'b0;
                     in_ready_o  <= 1'b1;
                     blk_data_o  <= '0;
                     blk_last_o  <= 1'b0;
                  end
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

`ifdef ASCON_PACK_STATS_EN
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i)                        blk_cnt_o <= '0;
      else if (blk_valid_o && blk_ready_i) blk_cnt_o <= blk_cnt_o + 16'd1;
   end
`endif

endmodule

// File: tb/tb_ascon_pad_packer.sv
// Directed self-checking bench for ascon_pad_packer (IN_BYTES=4, RATE_BYTES=16).
module tb_ascon_pad_packer;

   logic          clock_i = 1'b0;
   logic          reset_i = 1'b0;
   logic [31:0]   in_data_i = '0;
   logic [2:0]    in_nbytes_i = '0;
   logic          in_last_i = 1'b0;
   logic          in_type_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [127:0]  blk_data_o;
   logic [4:0]    blk_nbytes_o;
   logic          blk_type_o;
   logic          blk_last_o;
   logic          blk_valid_o;
   logic          blk_ready_i = 1'b0;
   logic          err_o;
`ifdef ASCON_PACK_STATS_EN
   logic [15:0]   blk_cnt_o;
`endif

   int n_err = 0;
   int n_chk = 0;

   ascon_pad_packer #(.IN_BYTES(4), .RATE_BYTES(16)) dut (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .in_data_i   (in_data_i),
      .in_nbytes_i (in_nbytes_i),
      .in_last_i   (in_last_i),
      .in_type_i   (in_type_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .blk_data_o  (blk_data_o),
      .blk_nbytes_o(blk_nbytes_o),
      .blk_type_o  (blk_type_o),
      .blk_last_o  (blk_last_o),
      .blk_valid_o (blk_valid_o),
      .blk_ready_i (blk_ready_i),
`ifdef ASCON_PACK_STATS_EN
      .blk_cnt_o   (blk_cnt_o),
`endif
      .err_o       (err_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_chk++;
      n_err++;
      $error("FAIL %s: observed timeout expected handshake", tag);
   endtask

   // Presents one beat and returns 1 time unit after the accepting edge.
   task automatic beat(input logic [31:0] d, input logic [2:0] n, input logic l, input logic t);
      int w = 0;
      @(negedge clock_i);
      in_data_i = d; in_nbytes_i = n; in_last_i = l; in_type_i = t; in_valid_i = 1'b1;
      while (!in_ready_o && w < 50) begin @(negedge clock_i); w++; end
      if (!in_ready_o) timeout("beat_ready");
      else @(posedge clock_i);
      #1 in_valid_i = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [127:0] d, input logic [4:0] n,
                       input logic l, input logic t);
      int w = 0;
      @(negedge clock_i);
      while (!blk_valid_o && w < 50) begin @(negedge clock_i); w++; end
      if (!blk_valid_o) timeout({tag, "_valid"});
      else begin
         chk({tag, "_data"},   blk_data_o,   d);
         chk({tag, "_nbytes"}, blk_nbytes_o, n);
         chk({tag, "_last"},   blk_last_o,   l);
         chk({tag, "_type"},   blk_type_o,   t);
         chk({tag, "_inrdy"},  in_ready_o,   1'b0);
         blk_ready_i = 1'b1;
         @(posedge clock_i);
         #1 blk_ready_i = 1'b0;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_inrdy"},  in_ready_o,   1'b0);
      chk({tag, "_valid"},  blk_valid_o,  1'b0);
      chk({tag, "_data"},   blk_data_o,   128'h0);
      chk({tag, "_nbytes"}, blk_nbytes_o, 5'd0);
      chk({tag, "_type"},   blk_type_o,   1'b0);
      chk({tag, "_last"},   blk_last_o,   1'b0);
      chk({tag, "_err"},    err_o,        1'b0);
   endtask

   initial begin
      // Reset: outputs held at zero, in_ready rises on first edge after release.
      #2 reset_i = 1'b1;
      #1 chk_all_zero("rst");
      repeat (3) @(posedge clock_i);
      #1 chk("rst_hold_inrdy", in_ready_o, 1'b0);
      @(negedge clock_i) reset_i = 1'b0;
      #1 chk("rel_inrdy_before_edge", in_ready_o, 1'b0);
      @(posedge clock_i);
      #1 chk("rel_inrdy_after_edge", in_ready_o, 1'b1);

      // 32-byte plaintext: two full blocks then a pad-only block.
      for (int i = 0; i < 4; i++)
         beat({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 3'd4, 1'b0, 1'b1);
      chk("pt_b0_latency", blk_valid_o, 1'b1);
      recv("pt_b0", 128'h0F0E0D0C0B0A09080706050403020100, 5'd16, 1'b0, 1'b1);
      chk("pt_b0_bubble_inrdy", in_ready_o, 1'b1);
      for (int i = 4; i < 8; i++)
         beat({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 3'd4, i == 7, 1'b1);
      recv("pt_b1", 128'h1F1E1D1C1B1A19181716151413121110, 5'd16, 1'b0, 1'b1);
      chk("pt_pad_valid", blk_valid_o, 1'b1);
      recv("pt_pad", 128'h1, 5'd0, 1'b1, 1'b1);
      chk("pt_done_valid", blk_valid_o, 1'b0);
`ifdef ASCON_PACK_STATS_EN
      chk("stats_cnt", blk_cnt_o, 16'd3);
`endif

      // Associated-data message, 12 bytes.
      beat(32'h63696C41, 3'd4, 1'b0, 1'b0);
      beat(32'h6F742065, 3'd4, 1'b0, 1'b0);
      beat(32'h626F4220, 3'd4, 1'b1, 1'b0);
      chk("ad_latency", blk_valid_o, 1'b1);
      recv("ad", 128'h00000001626F42206F74206563696C41, 5'd12, 1'b1, 1'b0);

      // Stall in EMIT: outputs stable for 5 cycles, one transfer on release.
      beat(32'hDDCCBBAA, 3'd4, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock_i);
         chk("stall_valid", blk_valid_o, 1'b1);
         chk("stall_data",  blk_data_o,  128'h0000000000000001DDCCBBAA);
         chk("stall_inrdy", in_ready_o,  1'b0);
      end
      recv("stall_rel", 128'h0000000000000001DDCCBBAA, 5'd4, 1'b1, 1'b0);
      chk("stall_single_xfer", blk_valid_o, 1'b0);

      // Short non-last beat sets sticky error; block still formed.
      chk("err_pre", err_o, 1'b0);
      beat(32'h11112222, 3'd2, 1'b0, 1'b0);
      chk("err_set", err_o, 1'b1);
      beat(32'h33445566, 3'd4, 1'b1, 1'b0);
      recv("err_blk", 128'h01334455662222, 5'd6, 1'b1, 1'b0);
      chk("err_sticky", err_o, 1'b1);

      // Reset mid-block discards the partial block and clears the error.
      beat(32'h11111111, 3'd4, 1'b0, 1'b1);
      beat(32'h22222222, 3'd4, 1'b0, 1'b1);
      @(negedge clock_i) reset_i = 1'b1;
      #1 chk_all_zero("mid_rst");
      @(negedge clock_i) reset_i = 1'b0;
      beat(32'h00AABBCC, 3'd3, 1'b1, 1'b0);
      recv("post_rst", 128'h01AABBCC, 5'd3, 1'b1, 1'b0);
      chk("post_rst_err", err_o, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ascon_pad_packer.md
ASCON_PAD_PACKER -- requirements
Module: ascon_pad_packer

Interface
REQ-001 Parameter IN_BYTES, default 4, input beat width in bytes; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter RATE_BYTES, default 16, output block width in bytes; legal values 8 and 16; RATE_BYTES SHALL be a multiple of IN_BYTES.
REQ-003 clock_i  in  1  single clock; all logic rising-edge.
REQ-004 reset_i  in  1  asynchronous, active-high reset.
REQ-005 in_data_i  in  8*IN_BYTES  beat data; byte k at bits [8k+7:8k], byte 0 first in message order.
REQ-006 in_nbytes_i  in  $clog2(IN_BYTES+1)  valid bytes in beat, 1..IN_BYTES.
REQ-007 in_last_i  in  1  final beat of message.
REQ-008 in_type_i  in  1  0 = associated data, 1 = plaintext.
REQ-009 in_valid_i / in_ready_o  in / out  1  input handshake; transfer when both high.
REQ-010 blk_data_o  out  8*RATE_BYTES  padded rate block, message byte 0 at bits [7:0].
REQ-011 blk_nbytes_o  out  $clog2(RATE_BYTES+1)  message bytes in block, 0..RATE_BYTES.
REQ-012 blk_type_o, blk_last_o  out  1 each  message type; final block of message.
REQ-013 blk_valid_o / blk_ready_i  out / in  1  output handshake; transfer when both high.
REQ-014 err_o  out  1  sticky protocol-error flag.

Function
REQ-015 States: FILL (in_ready_o=1, blk_valid_o=0), EMIT (in_ready_o=0, blk_valid_o=1), PADBLK (in_ready_o=0, blk_valid_o=1).
REQ-016 FILL: each accepted beat SHALL write its in_nbytes_i bytes at the current byte pointer; the pointer advances by in_nbytes_i.
REQ-017 FILL->EMIT on the accepting edge when the pointer reaches RATE_BYTES or in_last_i=1; blk_valid_o SHALL rise on the next cycle (latency 1 clock from the last contributing beat).
REQ-018 On last with pointer p<RATE_BYTES: byte p = 0x01, bytes p+1..RATE_BYTES-1 = 0x00, blk_nbytes_o=p, blk_last_o=1.
REQ-019 Full block without last: no padding, blk_nbytes_o=RATE_BYTES, blk_last_o=0.
REQ-020 Last beat exactly filling a block: emit the full block with blk_last_o=0, then go to PADBLK presenting data 0x01 in byte 0 (zeros elsewhere), blk_nbytes_o=0, blk_last_o=1.
REQ-021 EMIT/PADBLK: outputs SHALL hold stable while blk_ready_i=0; on transfer go to PADBLK (if pending) or FILL with the pointer and buffer cleared.
REQ-022 blk_type_o SHALL equal in_type_i of the first beat of the message.
REQ-023 Protocol errors, each setting err_o=1 until reset while the beat is still accepted: in_nbytes_i=0 or >IN_BYTES (treated as IN_BYTES); in_nbytes_i<IN_BYTES with in_last_i=0; in_type_i change mid-message (first-beat type retained).
REQ-024 Sustained throughput: one beat per clock within a block; one bubble per emitted block.

Reset
REQ-025 reset_i=1 SHALL immediately force FILL, pointer 0, buffer 0, pad-pending 0, err_o=0, blk_valid_o=0, blk_data_o=0, blk_nbytes_o=0, blk_type_o=0, blk_last_o=0, in_ready_o=0.
REQ-026 in_ready_o SHALL go to 1 on the first clock edge after reset_i deasserts; a partially filled block is discarded.

Configuration
REQ-027 Macro ASCON_PACK_STATS_EN defined: add output blk_cnt_o [15:0], reset 0, incremented on each output transfer, wrapping 0xFFFF->0x0000.
REQ-028 Macro not defined: blk_cnt_o port and counter SHALL be absent; all other behaviour is identical.

Verification (IN_BYTES=4, RATE_BYTES=16)
REQ-029 AD beats 0x63696C41, 0x6F742065, 0x626F4220(last, type 0) -> one block 128'h00000001626F42206F74206563696C41, nbytes 12, last 1, type 0.
REQ-030 32-byte plaintext (8 beats, last on 8th) -> two full blocks (nbytes 16, last 0), then a pad block 128'h...01, nbytes 0, last 1.
REQ-031 blk_ready_i held low 5 cycles in EMIT -> blk_valid_o, blk_data_o stable, in_ready_o=0 throughout; single transfer when released.
REQ-032 reset_i pulsed after 2 beats of a block -> all outputs 0 immediately; the next 3-byte last beat 0x00AABBCC yields 128'h...01AABBCC, nbytes 3.
REQ-033 Beat with in_nbytes_i=2 and in_last_i=0 -> err_o=1, remaining set until reset.
REQ-034 With ASCON_PACK_STATS_EN: after REQ-030 sequence -> blk_cnt_o=3.
